data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Word-organised data memory for the pipelined CPU's MEM stage.
- Supports word, halfword and byte stores and loads, selected by DMsel.
- Little-endian byte lanes; stores are synchronous, loads are combinational.
- Memory is asynchronously cleared by reset.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words (4 KiB). Must be a power of two.
- ADDR_W, 10: word-index width, equal to log2(DEPTH_WORDS).

Ports:
- clk  in  1  rising-edge clock for all writes.
- reset  in  1  asynchronous, active-high; clears every memory word to 0.
- Address  in  32  byte address. Word index is Address[ADDR_W+1:2]; higher bits are ignored (address wraps).
- DI  in  32  store data, right-justified (byte in DI[7:0], half in DI[15:0]).
- En  in  1  write enable; 1 = store on the next rising edge of clk.
- DMsel  in  2  access size: 2'b00 word, 2'b01 half, 2'b10 byte, 2'b11 reserved (treated as word).
- DO  out  32  load data, sign-extended for byte and half accesses.

Behaviour:
- Single clock; reset is asynchronous and active-high, on ports clk and reset.
- Reset: all words become 32'h0 immediately and DO follows combinationally (0 for any address). Reset has priority over a write in the same cycle.
- Writes occur at posedge clk when En=1 and reset=0. Let w = mem[Address word index].
  - Word: w <= DI. Address[1:0] is ignored; misaligned addresses are forced aligned.
  - Half: lane Address[1] (0 = bits 15:0, 1 = bits 31:16) <= DI[15:0]. Address[0] is ignored. Other lane unchanged.
  - Byte: lane Address[1:0] (0 = bits 7:0 … 3 = bits 31:24) <= DI[7:0]. Other lanes unchanged.
- Reads are combinational, with zero-cycle latency from Address, DMsel and memory contents. En does not gate DO.
  - Word: DO = w.
  - Half: DO = sign-extend(lane Address[1]).
  - Byte: DO = sign-extend(lane Address[1:0]).
- Read-during-write to the same word: DO shows the old value until the clock edge, and the new value after it. There is no write-through bypass.
- Initial contents before the first reset are 0.
- No error or exception outputs; misalignment is silently truncated.

Optional Feature:
- Macro: DM_WRITE_LOG_EN.
- When defined: each committed write emits a simulation $display line "@%h: *%h <= %h", printing $time, the word-aligned byte address and the full resulting 32-bit word.
- When undefined: no display code is compiled. Functional behaviour is identical in both cases.

Decomposition:
- Package data_memory_pkg:
  - DMsel encodings: SEL_WORD=2'b00, SEL_HALF=2'b01, SEL_BYTE=2'b10.
  - A function for the byte-enable mask derived from DMsel and Address[1:0].
- Sub-module dm_load_ext:
  - Combinational lane select plus sign-extension.
  - Inputs: word, Address[1:0], DMsel. Output: DO.
- The top level holds the array, the async clear, write-merge logic and the logging.

Test Plan:
- Reset: pulse reset=1 asynchronously between clock edges -> DO=0 for addresses 0, 4 and 0xFFC in all DMsel modes. A write with En=1 during reset is ignored.
- Byte then half then word to addr 0, DI=32'h87654321, on consecutive edges:
  - after byte store, mem[0]=32'h00000021;
  - after half store, 32'h00004321;
  - after word store, 32'h87654321.
- Byte loads with mem[0]=87654321, En=0, DMsel=10:
  - addr 1 -> 32'h00000043;
  - addr 2 -> 32'h00000065;
  - addr 3 -> 32'hFFFFFF87;
  - addr 4 -> 32'h0.
- Half loads, DMsel=01:
  - addr 1 -> 32'h00004321;
  - addr 2 -> 32'hFFFF8765;
  - addr 3 -> 32'hFFFF8765;
  - addr 4 -> 0.
- Word loads, DMsel=00: addrs 1, 2, 3 -> 32'h87654321; addr 4 -> 0. DMsel=11 behaves as word.
- Lane preservation and wrap:
  - Store byte 0xAA to addr 6 over word 0x11223344 at addr 4 -> 0x11AA3344.
  - Write to addr 0x1000 (DEPTH 1024) lands in word 0.

Source files
------------

// File: rtl/data_memory_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_pkg
//
// Shared definitions for the MEM-stage data memory:
//   - dm_sel_e       : access-size encoding carried on DMsel
//   - byte_en()      : 4-bit byte-lane enable for a store of a given size/offset
//   - lane_mask()    : expands a byte-lane enable into a 32-bit bit mask
//   - lane_replicate : copies right-justified store data into every lane it
//                      could land in, so a single mask selects the target lane
// -----------------------------------------------------------------------------
package data_memory_pkg;

    localparam int DEPTH_WORDS_DEFAULT = 1024;
    localparam int ADDR_W_DEFAULT      = 10;

    typedef enum logic [1:0] {
        SEL_WORD = 2'b00,
        SEL_HALF = 2'b01,
        SEL_BYTE = 2'b10,
        SEL_RSVD = 2'b11   // reserved encoding, behaves as a word access
    } dm_sel_e;

    // Byte-lane enable for a store. Offsets below the access size are ignored,
    // which silently aligns misaligned half and word accesses.
    function automatic logic [3:0] byte_en(input logic [1:0] sel,
                                           input logic [1:0] addr_lo);
        logic [3:0] be;
        case (dm_sel_e'(sel))
            SEL_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SEL_BYTE: be = 4'b0001 << addr_lo;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [1:0]  sel,
                                                   input logic [31:0] data);
        logic [31:0] rep;
        case (dm_sel_e'(sel))
            SEL_HALF: rep = {2{data[15:0]}};
            SEL_BYTE: rep = {4{data[7:0]}};
            default:  rep = data;
        endcase
        return rep;
    endfunction

endpackage : data_memory_pkg

// File: rtl/dm_load_ext.sv
// -----------------------------------------------------------------------------
// dm_load_ext
//
// Combinational load path: picks the addressed byte or halfword out of a
// 32-bit memory word and sign-extends it to 32 bits. Word and reserved
// accesses pass the word through unchanged.
//
// Ports:
//   word_i     [31:0]  memory word at the addressed word index
//   addr_lo_i  [1:0]   byte offset within the word (Address[1:0])
//   sel_i      [1:0]   access size (dm_sel_e encoding)
//   data_o     [31:0]  load result
// -----------------------------------------------------------------------------
module dm_load_ext
    import data_memory_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  sel_i,
    output logic [31:0] data_o
);

    logic [15:0] half_lane;
    logic [7:0]  byte_lane;

    // Halfword lane ignores Address[0]; byte lane uses the full offset.
    assign half_lane = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        byte_lane = word_i[7:0];
        case (addr_lo_i)
            2'd1:    byte_lane = word_i[15:8];
            2'd2:    byte_lane = word_i[23:16];
            2'd3:    byte_lane = word_i[31:24];
            default: byte_lane = word_i[7:0];
        endcase
    end

    always_comb begin
        data_o = word_i;
        case (dm_sel_e'(sel_i))
            SEL_HALF: data_o = {{16{half_lane[15]}}, half_lane};
            SEL_BYTE: data_o = {{24{byte_lane[7]}}, byte_lane};
            default:  data_o = word_i;
        endcase
    end

endmodule : dm_load_ext

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//
// Word-organised, little-endian data memory for the CPU MEM stage.
// Stores (word / half / byte) commit on the rising edge of clk; loads are
// combinational with sign extension for sub-word sizes. An active-high
// asynchronous reset clears every word. Address bits above the word index are
// ignored, so the address space wraps every DEPTH_WORDS*4 bytes.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two)
//   ADDR_W       word-index width, must equal log2(DEPTH_WORDS)
//
// Ports:
//   clk      in   1   write clock (rising edge)
//   reset    in   1   asynchronous active-high clear of all words
//   Address  in  32   byte address
//   DI       in  32   store data, right-justified
//   En       in   1   write enable
//   DMsel    in   2   access size: 00 word, 01 half, 10 byte, 11 word
//   DO       out 32   load data
//
// Build option:
//   DM_WRITE_LOG_EN  when defined, each committed write prints
//                    "@<time>: *<word address> <= <new word>" in simulation.
// -----------------------------------------------------------------------------
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int ADDR_W      = ADDR_W_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] DI,
    input  logic        En,
    input  logic [1:0]  DMsel,
    output logic [31:0] DO
);

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       cur_word;
    logic [3:0]        wr_be;
    logic [31:0]       wr_mask;
    logic [31:0]       wr_data_rep;
    logic [31:0]       wr_word_d;

    // Upper address bits are deliberately dropped to give wrap-around.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^Address[31:ADDR_W+2];

    assign word_idx = Address[ADDR_W+1:2];
    assign cur_word = mem_q[word_idx];

    // Write merge: replicate the store data into all candidate lanes, then let
    // the byte-enable mask choose which lanes take new data and which keep the
    // current contents.
    always_comb begin
        wr_be       = byte_en(DMsel, Address[1:0]);
        wr_mask     = lane_mask(wr_be);
        wr_data_rep = lane_replicate(DMsel, DI);
        wr_word_d   = (cur_word & ~wr_mask) | (wr_data_rep & wr_mask);
    end

    // NOTE: the array sits in the async reset branch on purpose, because the
    // memory must read as zero the instant reset rises; this forces flops
    // rather than an SRAM macro, which is the price of that behaviour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (En) begin
            // NOTE: state updates use non-blocking assignment so a load in
            // this cycle sees the old word and the new word appears after the
            // edge, with no write-through bypass.
            mem_q[word_idx] <= wr_word_d;
        end
    end

    dm_load_ext u_load_ext (
        .word_i    (cur_word),
        .addr_lo_i (Address[1:0]),
        .sel_i     (DMsel),
        .data_o    (DO)
    );

`ifdef DM_WRITE_LOG_EN
    always_ff @(posedge clk) begin
        if (!reset && En) begin
            $display("@%h: *%h <= %h", $time, {Address[31:2], 2'b00}, wr_word_d);
        end
    end
`else
    // Logging compiled out; the datapath above is identical either way.
`endif

endmodule : data_memory

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
//
// Directed bench for data_memory. Inputs change on the falling edge; outputs
// are sampled 1 time unit after inputs settle, away from the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_memory;

    localparam logic [1:0] W  = 2'b00;
    localparam logic [1:0] H  = 2'b01;
    localparam logic [1:0] B  = 2'b10;
    localparam logic [1:0] RS = 2'b11;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] DI;
    logic        En;
    logic [1:0]  DMsel;
    logic [31:0] DO;

    int checks;
    int errors;

    data_memory #(
        .DEPTH_WORDS (1024),
        .ADDR_W      (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .Address (Address),
        .DI      (DI),
        .En      (En),
        .DMsel   (DMsel),
        .DO      (DO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers (no comparisons inside).
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] sel);
        @(negedge clk);
        Address = addr;
        DI      = data;
        DMsel   = sel;
        En      = 1'b1;
        @(posedge clk);
        #1;
        En = 1'b0;
    endtask

    task automatic set_read(input logic [31:0] addr, input logic [1:0] sel);
        Address = addr;
        DMsel   = sel;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [3];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'hFFC;
        // Dirty a word so the clear has something to remove.
        do_write(32'h0, 32'hDEADBEEF, W);
        set_read(32'h0, W);
        checks++;
        if (DO !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL pre_reset_write: got %h want %h", DO, 32'hDEADBEEF);
        end
        // Raise reset between edges; DO must clear without a clock edge.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (DO !== 32'h0) begin
            errors++;
            $display("FAIL reset_async_clear: got %h want %h", DO, 32'h0);
        end
        // A write attempted while reset is high must be ignored.
        Address = 32'h4; DI = 32'hFFFFFFFF; DMsel = W; En = 1'b1;
        @(posedge clk);
        #1;
        En = 1'b0;
        for (int a = 0; a < 3; a++) begin
            for (int s = 0; s < 4; s++) begin
                set_read(addrs[a], s[1:0]);
                checks++;
                if (DO !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_zero addr=%h sel=%0d: got %h want %h",
                             addrs[a], s, DO, 32'h0);
                end
            end
        end
        @(negedge clk);
        reset = 1'b0;
        set_read(32'h4, W);
        checks++;
        if (DO !== 32'h0) begin
            errors++;
            $display("FAIL reset_write_ignored: got %h want %h", DO, 32'h0);
        end
    endtask

    task automatic test_store_sizes();
        logic [1:0]  sels [3];
        logic [31:0] exp  [3];
        sels[0] = B; exp[0] = 32'h00000021;
        sels[1] = H; exp[1] = 32'h00004321;
        sels[2] = W; exp[2] = 32'h87654321;
        for (int i = 0; i < 3; i++) begin
            do_write(32'h0, 32'h87654321, sels[i]);
            set_read(32'h0, W);
            checks++;
            if (DO !== exp[i]) begin
                errors++;
                $display("FAIL store_size step %0d: got %h want %h", i, DO, exp[i]);
            end
        end
    endtask

    task automatic test_loads();
        logic [31:0] addr [16];
        logic [1:0]  sel  [16];
        logic [31:0] exp  [16];
        addr[0]  = 32'd0; sel[0]  = B;  exp[0]  = 32'h00000021;
        addr[1]  = 32'd1; sel[1]  = B;  exp[1]  = 32'h00000043;
        addr[2]  = 32'd2; sel[2]  = B;  exp[2]  = 32'h00000065;
        addr[3]  = 32'd3; sel[3]  = B;  exp[3]  = 32'hFFFFFF87;
        addr[4]  = 32'd4; sel[4]  = B;  exp[4]  = 32'h00000000;
        addr[5]  = 32'd1; sel[5]  = H;  exp[5]  = 32'h00004321;
        addr[6]  = 32'd2; sel[6]  = H;  exp[6]  = 32'hFFFF8765;
        addr[7]  = 32'd3; sel[7]  = H;  exp[7]  = 32'hFFFF8765;
        addr[8]  = 32'd4; sel[8]  = H;  exp[8]  = 32'h00000000;
        addr[9]  = 32'd1; sel[9]  = W;  exp[9]  = 32'h87654321;
        addr[10] = 32'd2; sel[10] = W;  exp[10] = 32'h87654321;
        addr[11] = 32'd3; sel[11] = W;  exp[11] = 32'h87654321;
        addr[12] = 32'd4; sel[12] = W;  exp[12] = 32'h00000000;
        addr[13] = 32'd0; sel[13] = RS; exp[13] = 32'h87654321;
        addr[14] = 32'd3; sel[14] = RS; exp[14] = 32'h87654321;
        addr[15] = 32'd0; sel[15] = H;  exp[15] = 32'h00004321;
        for (int i = 0; i < 16; i++) begin
            set_read(addr[i], sel[i]);
            checks++;
            if (DO !== exp[i]) begin
                errors++;
                $display("FAIL load addr=%h sel=%0d: got %h want %h",
                         addr[i], sel[i], DO, exp[i]);
            end
        end
    endtask

    task automatic test_lane_preserve();
        do_write(32'h4, 32'h11223344, W);
        do_write(32'h6, 32'h000000AA, B);
        set_read(32'h4, W);
        checks++;
        if (DO !== 32'h11AA3344) begin
            errors++;
            $display("FAIL lane_byte_preserve: got %h want %h", DO, 32'h11AA3344);
        end
        // Upper half store to top word, misaligned by one byte.
        do_write(32'hFFC, 32'h12345678, W);
        do_write(32'hFFF, 32'h0000BEEF, H);
        set_read(32'hFFC, W);
        checks++;
        if (DO !== 32'hBEEF5678) begin
            errors++;
            $display("FAIL lane_half_preserve: got %h want %h", DO, 32'hBEEF5678);
        end
        set_read(32'hFFE, H);
        checks++;
        if (DO !== 32'hFFFFBEEF) begin
            errors++;
            $display("FAIL half_sign_ext_top: got %h want %h", DO, 32'hFFFFBEEF);
        end
        // Misaligned word store is forced aligned.
        do_write(32'h0B, 32'hA5A5C3C3, W);
        set_read(32'h08, W);
        checks++;
        if (DO !== 32'hA5A5C3C3) begin
            errors++;
            $display("FAIL word_misaligned: got %h want %h", DO, 32'hA5A5C3C3);
        end
    endtask

    task automatic test_wrap();
        do_write(32'h1000, 32'hCAFEF00D, W);
        set_read(32'h0, W);
        checks++;
        if (DO !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL wrap_to_word0: got %h want %h", DO, 32'hCAFEF00D);
        end
        set_read(32'hFFFF_F004, W);
        checks++;
        if (DO !== 32'h11AA3344) begin
            errors++;
            $display("FAIL wrap_high_read: got %h want %h", DO, 32'h11AA3344);
        end
    endtask

    task automatic test_read_during_write();
        @(negedge clk);
        Address = 32'h10; DI = 32'h5A5A5A5A; DMsel = W; En = 1'b1;
        #1;
        checks++;
        if (DO !== 32'h0) begin
            errors++;
            $display("FAIL rdw_old_value: got %h want %h", DO, 32'h0);
        end
        @(posedge clk);
        #1;
        En = 1'b0;
        #1;
        checks++;
        if (DO !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL rdw_new_value: got %h want %h", DO, 32'h5A5A5A5A);
        end
        // En low: a changed DI must not reach memory.
        @(negedge clk);
        DI = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        checks++;
        if (DO !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL en_low_no_write: got %h want %h", DO, 32'h5A5A5A5A);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        Address = '0;
        DI      = '0;
        En      = 1'b0;
        DMsel   = W;
        #3;
        reset = 1'b0;

        test_reset();
        test_store_sizes();
        test_loads();
        test_lane_preserve();
        test_wrap();
        test_read_during_write();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_data_memory
